// File: rtl/gray_count_rx.sv
// Receive-side Gray counter endpoint: synchronize, convert, derive modular step, accumulate.
// Optional glitch filter enabled by defining GRAY_RX_GLITCH_FILTER_EN.
module gray_count_rx #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MAX_STEP    = 7,
  parameter int unsigned ACC_WIDTH   = 16
) (
  input  logic                 clk2,
  input  logic                 reset_n,
  input  logic [WIDTH-1:0]     gray_in,
  input  logic                 clear,
  output logic [WIDTH-1:0]     count_bin,
  output logic [WIDTH-1:0]     delta,
  output logic                 upd,
  output logic [ACC_WIDTH-1:0] total,
  output logic                 overrun
);

  typedef enum logic [1:0] {INIT, PRIME, TRACK} state_t;

  localparam logic [WIDTH-1:0] MAX_STEP_W = WIDTH'(MAX_STEP);

  state_t                 state_q, state_d;
  logic [2:0]             init_cnt_q, init_cnt_d;
  logic [WIDTH-1:0]       sync_q [SYNC_STAGES];
  logic [WIDTH-1:0]       sync_d [SYNC_STAGES];
  logic [WIDTH-1:0]       conv;
  logic [WIDTH-1:0]       conv_q;
  logic [WIDTH-1:0]       count_bin_q, count_bin_d;
  logic [WIDTH-1:0]       delta_q, delta_d;
  logic                   upd_q, upd_d;
  logic [ACC_WIDTH-1:0]   total_q, total_d;
  logic                   overrun_q, overrun_d;
  logic [WIDTH-1:0]       step;
  logic [ACC_WIDTH:0]     sum;
  logic                   eval;
`ifdef GRAY_RX_GLITCH_FILTER_EN
  logic [WIDTH-1:0]       prev_q;
`endif

  always_comb begin
    sync_d[0] = gray_in;
    for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  // Bit i of the binary value is the XOR of all Gray bits at or above i.
  always_comb begin
    conv = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      conv[i] = ^(sync_q[SYNC_STAGES-1] >> i);
    end
  end

`ifdef GRAY_RX_GLITCH_FILTER_EN
  always_comb eval = (conv_q == prev_q);
`else
  always_comb eval = 1'b1;
`endif

  always_comb begin
    step = conv_q - count_bin_q;
    sum  = {1'b0, total_q} + (ACC_WIDTH+1)'(step);
  end

  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    count_bin_d = count_bin_q;
    delta_d     = delta_q;
    upd_d       = 1'b0;
    total_d     = total_q;
    overrun_d   = overrun_q;
    case (state_q)
      INIT: begin
        if (init_cnt_q == 3'(SYNC_STAGES - 1)) begin
          state_d = PRIME;
        end else begin
          init_cnt_d = init_cnt_q + 3'd1;
        end
      end
      // Prime straight from the last sync stage so conv_q is already aligned in TRACK.
      PRIME: begin
        count_bin_d = conv;
        state_d     = TRACK;
      end
      TRACK: begin
        if (eval && (step != '0)) begin
          count_bin_d = conv_q;
          delta_d     = step;
          upd_d       = 1'b1;
          total_d     = sum[ACC_WIDTH] ? '1 : sum[ACC_WIDTH-1:0];
          if (step > MAX_STEP_W) begin
            overrun_d = 1'b1;
          end
        end
      end
      default: state_d = INIT;
    endcase
    if (clear) begin
      total_d   = '0;
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk2 or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      conv_q      <= '0;
      state_q     <= INIT;
      init_cnt_q  <= '0;
      count_bin_q <= '0;
      delta_q     <= '0;
      upd_q       <= 1'b0;
      total_q     <= '0;
      overrun_q   <= 1'b0;
`ifdef GRAY_RX_GLITCH_FILTER_EN
      prev_q      <= '0;
`endif
    end else begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
      conv_q      <= conv;
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      count_bin_q <= count_bin_d;
      delta_q     <= delta_d;
      upd_q       <= upd_d;
      total_q     <= total_d;
      overrun_q   <= overrun_d;
`ifdef GRAY_RX_GLITCH_FILTER_EN
      prev_q      <= conv_q;
`endif
    end
  end

  assign count_bin = count_bin_q;
  assign delta     = delta_q;
  assign upd       = upd_q;
  assign total     = total_q;
  assign overrun   = overrun_q;

endmodule
